// File: rtl/button_gesture_decoder_if.sv
// Button gesture decoder bundle: debounced level in, gesture pulses out.
// master drives the level, slave is the decoder.
interface button_gesture_decoder_if;
  logic btn_level;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output btn_level,
    input  short_press,
    input  double_press,
    input  long_press,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  btn_level,
    output short_press,
    output double_press,
    output long_press,
    output repeat_pulse,
    output busy
  );
endinterface

// File: rtl/button_gesture_decoder.sv
// Classifies debounced presses into short/double/long one-cycle pulses.
// Optional macro AUTO_REPEAT_EN adds periodic repeat pulses during long holds.
module button_gesture_decoder #(
  parameter int LONG_TICKS   = 50_000_000,
  parameter int DBL_TICKS    = 15_000_000,
  parameter int REPEAT_TICKS = 10_000_000,
  parameter int CNT_W        = 27
) (
  input logic clk,
  input logic rst_n,
  button_gesture_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_short;
  logic             r_dbl;
  logic             r_long;
  logic             r_busy;
  logic             w_short_nxt;
  logic             w_dbl_nxt;
  logic             w_long_nxt;
  logic             w_lvl;

  assign w_lvl = bus.btn_level;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic r_rep;
  logic w_rep_nxt;
`endif

  // Next-state, counter and pulse decode; counter clears on any state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short_nxt = 1'b0;
    w_dbl_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
`ifdef AUTO_REPEAT_EN
    w_rep_nxt   = 1'b0;
`endif
    unique case (r_state)
      ARM: begin
        if (!w_lvl) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_lvl) w_state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!w_lvl) begin
          w_state_nxt = WAIT2;
        end else if (r_cnt == LONG_LAST) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      WAIT2: begin
        if (w_lvl) begin
          w_dbl_nxt   = 1'b1;
          w_state_nxt = PRESS2;
        end else if (r_cnt == DBL_LAST) begin
          w_short_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (!w_lvl) w_state_nxt = IDLE;
      end
      HELD: begin
        if (!w_lvl) begin
          w_state_nxt = IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (r_cnt == REP_LAST) begin
          w_rep_nxt = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
`endif
      end
      default: begin
        w_state_nxt = ARM;
      end
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // State, counter and registered outputs; reset parks in ARM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARM;
      r_cnt   <= '0;
      r_short <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_short <= w_short_nxt;
      r_dbl   <= w_dbl_nxt;
      r_long  <= w_long_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

`ifdef AUTO_REPEAT_EN
  // Repeat pulse register, only present with auto-repeat.
  always_ff @(posedge clk) begin
    if (!rst_n) r_rep <= 1'b0;
    else        r_rep <= w_rep_nxt;
  end

  assign bus.repeat_pulse = r_rep;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.short_press  = r_short;
  assign bus.double_press = r_dbl;
  assign bus.long_press   = r_long;
  assign bus.busy         = r_busy;

endmodule
